unidade_controle_param: RTL and testbench

UNIDADE_CONTROLE_PARAM -- requirements
Module: unidade_controle_param

---
 rtl/jogo_pkg.sv | 30 +++
 rtl/contador_tempo.sv | 26 ++
 rtl/unidade_controle_param.sv | 166 ++++++++++++++++
 tb/tb_unidade_controle_param.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/jogo_pkg.sv
// Shared definitions for the memory-game control unit: state codes and parameter defaults.
package jogo_pkg;

    typedef enum logic [3:0] {
        INICIAL        = 4'h0,
        PREPARA        = 4'h1,
        INICIO_RODADA  = 4'h2,
        MOSTRA         = 4'h3,
        APAGA          = 4'h4,
        ESPERA_JOGADA  = 4'h5,
        PAUSADO        = 4'h6,
        REGISTRA       = 4'h7,
        COMPARA        = 4'h8,
        PROXIMA_JOGADA = 4'h9,
        PROXIMA_RODADA = 4'hA,
        ERROU_VIDA     = 4'hB,
        GANHOU         = 4'hC,
        PERDEU         = 4'hD
    } estado_t;

    localparam int NUM_RODADAS_PAD  = 16;
    localparam int TEMPO_MOSTRA_PAD = 1000;
    localparam int TEMPO_JOGADA_PAD = 5000;
    localparam int VIDAS_PAD        = 3;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/contador_tempo.sv
// Interval timer: clear, count or hold, with an equality compare against a supplied limit.
module contador_tempo #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         zera,
    input  logic         conta,
    input  logic [W-1:0] limite,
    output logic         fim
);

    logic [W-1:0] valor;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            valor <= '0;
        else if (zera)
            valor <= '0;
        else if (conta)
            valor <= valor + W'(1);
    end

    assign fim = (valor == limite);

endmodule

// File: rtl/unidade_controle_param.sv
// Control unit for a memory game: shows a growing LED sequence, times player moves,
// tracks rounds and lives, and supports pausing while waiting for a move.
module unidade_controle_param
    import jogo_pkg::*;
#(
    parameter int NUM_RODADAS  = NUM_RODADAS_PAD,
    parameter int TEMPO_MOSTRA = TEMPO_MOSTRA_PAD,
    parameter int TEMPO_JOGADA = TEMPO_JOGADA_PAD,
    parameter int VIDAS        = VIDAS_PAD,
    localparam int AW = $clog2(NUM_RODADAS),
    localparam int VW = $clog2(VIDAS + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          iniciar,
    input  logic          pausa,
    input  logic          jogada_feita,
    input  logic          jogada_correta,
    input  logic          nivel_rodadas,
    output logic [AW-1:0] endereco,
    output logic [AW-1:0] rodada,
    output logic [VW-1:0] vidas,
    output logic          ativa_leds_mem,
    output logic          vez_jogador,
    output logic          registraR,
    output logic          pronto,
    output logic          ganhou,
    output logic          perdeu,
    output logic          db_timeout,
    output logic [3:0]    db_estado
);

    localparam int TW = max_int(1, $clog2(max_int(TEMPO_MOSTRA, TEMPO_JOGADA)));
    localparam logic [TW-1:0] FIM_MOSTRA = TW'(TEMPO_MOSTRA - 1);
    localparam logic [TW-1:0] FIM_JOGADA = TW'(TEMPO_JOGADA - 1);

    estado_t       estado, prox;
    logic [AW-1:0] ultima;
    logic          fim, zera, conta;
    logic [TW-1:0] limite;
    logic          ultima_vida;

    assign ultima_vida = (vidas <= VW'(1));

    // The same timer serves the LED intervals and the move window.
    assign limite = (estado == ESPERA_JOGADA || estado == PAUSADO) ? FIM_JOGADA : FIM_MOSTRA;
    assign zera   = (estado == INICIO_RODADA) || (estado == PROXIMA_JOGADA) ||
                    ((estado == MOSTRA || estado == APAGA) && fim);
    assign conta  = (estado == MOSTRA) || (estado == APAGA) ||
                    (estado == ESPERA_JOGADA && !pausa && !fim);

    contador_tempo #(.W(TW)) u_timer (
        .clock  (clock),
        .reset  (reset),
        .zera   (zera),
        .conta  (conta),
        .limite (limite),
        .fim    (fim)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            estado <= INICIAL;
        else
            estado <= prox;
    end

    always_comb begin
        prox = estado;
        case (estado)
            INICIAL:        if (iniciar) prox = PREPARA;
            PREPARA:        prox = INICIO_RODADA;
            INICIO_RODADA:  prox = MOSTRA;
            MOSTRA:         if (fim) prox = APAGA;
            APAGA:          if (fim) prox = (endereco == rodada) ? ESPERA_JOGADA : MOSTRA;
            ESPERA_JOGADA: begin
                if (pausa)
                    prox = PAUSADO;
                else if (fim)
                    prox = ultima_vida ? PERDEU : ERROU_VIDA;
                else if (jogada_feita)
                    prox = REGISTRA;
            end
            PAUSADO:        if (!pausa) prox = ESPERA_JOGADA;
            REGISTRA:       prox = COMPARA;
            COMPARA: begin
                if (!jogada_correta)
                    prox = ultima_vida ? PERDEU : ERROU_VIDA;
                else if (endereco < rodada)
                    prox = PROXIMA_JOGADA;
                else if (rodada == ultima)
                    prox = GANHOU;
                else
                    prox = PROXIMA_RODADA;
            end
            PROXIMA_JOGADA: prox = ESPERA_JOGADA;
            PROXIMA_RODADA: prox = INICIO_RODADA;
            ERROU_VIDA:     prox = INICIO_RODADA;
            GANHOU, PERDEU: if (iniciar) prox = PREPARA;
            default:        prox = INICIAL;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            endereco   <= '0;
            rodada     <= '0;
            vidas      <= '0;
            db_timeout <= 1'b0;
            ultima     <= '0;
        end else begin
            case (estado)
                PREPARA: begin
                    rodada     <= '0;
                    vidas      <= VW'(VIDAS);
                    db_timeout <= 1'b0;
                    ultima     <= nivel_rodadas ? AW'(NUM_RODADAS - 1) : AW'(NUM_RODADAS / 2 - 1);
                end
                INICIO_RODADA:  endereco <= '0;
                APAGA:
                    if (fim) endereco <= (endereco == rodada) ? '0 : endereco + AW'(1);
                ESPERA_JOGADA:
                    // Final timeout: no life left to spend, flag the cause.
                    if (!pausa && fim && ultima_vida) begin
                        vidas      <= '0;
                        db_timeout <= 1'b1;
                    end
                COMPARA:
                    if (!jogada_correta && ultima_vida) begin
                        vidas      <= '0;
                        db_timeout <= 1'b0;
                    end
                PROXIMA_JOGADA: endereco <= endereco + AW'(1);
                PROXIMA_RODADA: rodada   <= rodada + AW'(1);
                ERROU_VIDA:     vidas    <= vidas - VW'(1);
                default: ;
            endcase
        end
    end

    always_comb begin
        ativa_leds_mem = 1'b0;
        vez_jogador    = 1'b0;
        registraR      = 1'b0;
        pronto         = 1'b0;
        ganhou         = 1'b0;
        perdeu         = 1'b0;
        case (estado)
            MOSTRA:        ativa_leds_mem = 1'b1;
            ESPERA_JOGADA: vez_jogador    = 1'b1;
            REGISTRA:      registraR      = 1'b1;
            GANHOU: begin
                pronto = 1'b1;
                ganhou = 1'b1;
            end
            PERDEU: begin
                pronto = 1'b1;
                perdeu = 1'b1;
            end
            default: ;
        endcase
    end

    assign db_estado = estado;

endmodule

// File: tb/tb_unidade_controle_param.sv
// Scoreboard bench: stimulus queues expected move-window and end-of-game records,
// a monitor pops and compares them whenever the DUT opens a move window or finishes.
module tb_unidade_controle_param;

    localparam int NR = 4;
    localparam int TM = 4;
    localparam int TJ = 10;
    localparam int VD = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       iniciar = 1'b0, pausa = 1'b0, jogada_feita = 1'b0, jogada_correta = 1'b0;
    logic       nivel_rodadas = 1'b0;
    logic [1:0] endereco, rodada, vidas;
    logic       ativa_leds_mem, vez_jogador, registraR, pronto, ganhou, perdeu, db_timeout;
    logic [3:0] db_estado;

    unidade_controle_param #(
        .NUM_RODADAS(NR), .TEMPO_MOSTRA(TM), .TEMPO_JOGADA(TJ), .VIDAS(VD)
    ) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .pausa(pausa),
        .jogada_feita(jogada_feita), .jogada_correta(jogada_correta),
        .nivel_rodadas(nivel_rodadas), .endereco(endereco), .rodada(rodada),
        .vidas(vidas), .ativa_leds_mem(ativa_leds_mem), .vez_jogador(vez_jogador),
        .registraR(registraR), .pronto(pronto), .ganhou(ganhou), .perdeu(perdeu),
        .db_timeout(db_timeout), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    typedef struct {
        int kind;      // 0: move window opened, 1: game over
        int rodada;
        int endereco;
        int vidas;
        int leds;
        int ganhou;
        int perdeu;
        int dbt;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_vez(input int r, input int e, input int v, input int l);
        exp_t x;
        x = '{kind: 0, rodada: r, endereco: e, vidas: v, leds: l, ganhou: 0, perdeu: 0, dbt: 0};
        q.push_back(x);
    endtask

    task automatic push_fim(input int r, input int v, input int g, input int p, input int t);
        exp_t x;
        x = '{kind: 1, rodada: r, endereco: 0, vidas: v, leds: 0, ganhou: g, perdeu: p, dbt: t};
        q.push_back(x);
    endtask

    // Monitor
    int  leds_since, led_len;
    logic pv, pp, pl;
    initial begin
        exp_t e;
        pv = 0; pp = 0; pl = 0; leds_since = 0; led_len = 0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                pv = 0; pp = 0; pl = 0; leds_since = 0; led_len = 0;
            end else begin
                if (ativa_leds_mem) led_len++;
                if (ativa_leds_mem && !pl) leds_since++;
                if (!ativa_leds_mem && pl) begin
                    chk("led_on_len", led_len, TM);
                    led_len = 0;
                end
                if (vez_jogador && !pv) begin
                    if (q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_vez: got move window, required none");
                    end else begin
                        e = q.pop_front();
                        chk("vez_kind", 0, e.kind);
                        chk("vez_rodada", int'(rodada), e.rodada);
                        chk("vez_endereco", int'(endereco), e.endereco);
                        chk("vez_vidas", int'(vidas), e.vidas);
                        chk("vez_leds", leds_since, e.leds);
                    end
                    leds_since = 0;
                end
                if (pronto && !pp) begin
                    if (q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_end: got game over, required none");
                    end else begin
                        e = q.pop_front();
                        chk("end_kind", 1, e.kind);
                        chk("end_rodada", int'(rodada), e.rodada);
                        chk("end_vidas", int'(vidas), e.vidas);
                        chk("end_ganhou", int'(ganhou), e.ganhou);
                        chk("end_perdeu", int'(perdeu), e.perdeu);
                        chk("end_db_timeout", int'(db_timeout), e.dbt);
                    end
                end
                pv = vez_jogador; pp = pronto; pl = ativa_leds_mem;
            end
        end
    end

    task automatic wait_vez(output int ok);
        ok = 0;
        for (int i = 0; i < 400 && ok == 0; i++) begin
            @(negedge clock);
            if (vez_jogador) ok = 1;
        end
        if (ok == 0) begin
            total++; bad++;
            $display("FAIL wait_vez: got no move window within 400 cycles");
        end
    endtask

    task automatic wait_pronto();
        int ok;
        ok = 0;
        for (int i = 0; i < 400 && ok == 0; i++) begin
            @(negedge clock);
            if (pronto) ok = 1;
        end
        if (ok == 0) begin
            total++; bad++;
            $display("FAIL wait_pronto: got no game over within 400 cycles");
        end
    endtask

    task automatic jogar(input logic c);
        int ok;
        wait_vez(ok);
        if (ok != 0) begin
            jogada_correta = c;
            jogada_feita   = 1'b1;
            @(negedge clock);
            jogada_feita   = 1'b0;
        end
    endtask

    // Counts cycles the move window stays open when the player does nothing.
    task automatic janela(input string name, input int exp_len);
        int ok, n, done;
        wait_vez(ok);
        if (ok != 0) begin
            n = 1; done = 0;
            for (int i = 0; i < 100 && done == 0; i++) begin
                @(negedge clock);
                if (vez_jogador) n++; else done = 1;
            end
            chk(name, n, exp_len);
        end
    endtask

    task automatic comecar(input logic niv);
        nivel_rodadas = niv;
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1);
    end

    initial begin
        int ok, found;

        // Reset state
        repeat (3) @(negedge clock);
        chk("rst_estado", int'(db_estado), 0);
        chk("rst_rodada", int'(rodada), 0);
        chk("rst_vidas", int'(vidas), 0);
        chk("rst_endereco", int'(endereco), 0);
        chk("rst_status", int'({ativa_leds_mem, vez_jogador, registraR, pronto, ganhou, perdeu, db_timeout}), 0);
        reset = 1'b1;
        @(negedge clock);
        chk("idle_estado", int'(db_estado), 0);

        // Short game, all correct
        push_vez(0, 0, 2, 1);
        push_vez(1, 0, 2, 2);
        push_vez(1, 1, 2, 0);
        push_fim(1, 2, 1, 0, 0);
        comecar(1'b0);
        jogar(1'b1); jogar(1'b1); jogar(1'b1);
        wait_pronto();

        // Long game, two wrong moves in round 2
        push_vez(0, 0, 2, 1);
        push_vez(1, 0, 2, 2);
        push_vez(1, 1, 2, 0);
        push_vez(2, 0, 2, 3);
        push_vez(2, 1, 2, 0);
        push_vez(2, 0, 1, 3);
        push_fim(2, 0, 0, 1, 0);
        comecar(1'b1);
        jogar(1'b1); jogar(1'b1); jogar(1'b1); jogar(1'b1);
        jogar(1'b0); jogar(1'b0);
        wait_pronto();

        // Two timeouts
        push_vez(0, 0, 2, 1);
        push_vez(0, 0, 1, 1);
        push_fim(0, 0, 0, 1, 1);
        comecar(1'b0);
        janela("timeout_len1", TJ);
        janela("timeout_len2", TJ);
        wait_pronto();

        // Pause at timer 6, then timeout after resume, then reset mid-show
        push_vez(0, 0, 2, 1);
        push_vez(0, 0, 2, 0);
        push_vez(0, 0, 1, 1);
        comecar(1'b0);
        wait_vez(ok);
        repeat (6) @(negedge clock);
        pausa = 1'b1;
        repeat (2) @(negedge clock);
        chk("paused_estado", int'(db_estado), 6);
        jogada_feita = 1'b1;
        @(negedge clock);
        jogada_feita = 1'b0;
        repeat (47) @(negedge clock);
        chk("paused_vez", int'(vez_jogador), 0);
        pausa = 1'b0;
        janela("resume_len", TJ - 6);
        jogar(1'b1);
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            @(negedge clock);
            if (ativa_leds_mem && rodada == 2'd1) found = 1;
        end
        chk("reached_show_r1", found, 1);
        reset = 1'b0;
        #1;
        chk("midrst_estado", int'(db_estado), 0);
        chk("midrst_rodada", int'(rodada), 0);
        chk("midrst_vidas", int'(vidas), 0);
        chk("midrst_status", int'({ativa_leds_mem, pronto, ganhou, perdeu, db_timeout}), 0);
        chk("midrst_queue", q.size(), 0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        // Clean restart after reset
        push_vez(0, 0, 2, 1);
        push_vez(1, 0, 2, 2);
        push_vez(1, 1, 2, 0);
        push_fim(1, 2, 1, 0, 0);
        comecar(1'b0);
        jogar(1'b1); jogar(1'b1); jogar(1'b1);
        wait_pronto();
        @(negedge clock);

        chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
